// File: rtl/char_disp_pkg.sv
// Shared definitions for the character display scheduler.
// Holds the display FSM state type, the default blank character and a width
// helper. The helper turns a count into a bit width that is never zero, so
// degenerate parameters such as a single requester still produce legal
// vectors.
package char_disp_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } dispState_e;

    localparam logic [7:0] DEFAULT_IDLE_CHAR = 8'h00;

    // Bits needed to index n items. Values of 1 and 2 both need one bit.
    function automatic int widthOf(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/char_display_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
// The search starts one past the previous owner and wraps modulo NUM_REQ.
// At most one grant bit is set.
// Ports:
//   reqVec_i     - request vector, one bit per requester
//   lastOwner_i  - index of the previously granted requester
//   grant_o      - one-hot grant, all zero when nobody requests
//   grantIdx_o   - encoded index of the granted requester
//   any_o        - high when at least one request is present
module rr_arbiter
    import char_disp_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = widthOf(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] reqVec_i,
    input  logic [IDX_W-1:0]   lastOwner_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grantIdx_o,
    output logic               any_o
);

    // The search steps through the candidates in priority order. The first
    // requester it finds wins. Each candidate's request bit is shifted down
    // into bit 0. The index width does not have to match the vector width,
    // so this also covers NUM_REQ=1, where the arbiter becomes the identity.
    always_comb begin
        int                 cand;
        logic [NUM_REQ-1:0] shifted;
        grant_o    = '0;
        grantIdx_o = '0;
        any_o      = 1'b0;
        cand       = 0;
        shifted    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand    = (int'(lastOwner_i) + k) % NUM_REQ;
            shifted = reqVec_i >> cand;
            if (!any_o && shifted[0]) begin
                any_o      = 1'b1;
                grant_o    = NUM_REQ'(1) << cand;
                grantIdx_o = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/char_display_scheduler.sv
// char_display_scheduler: lets up to NUM_REQ requesters share one 8-bit
// character display.
// A round-robin arbiter picks a requester. The requester's character is
// accepted with a valid/ready handshake. The character is then shown for
// exactly DWELL_TICKS * TICK_DIV cycles. When a dwell expires and a request
// is waiting, the next character follows with no blank cycle between them.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   req_valid   - per-requester offer of a character
//   req_char    - packed characters, requester i in bits [8i+7:8i]
//   req_ready   - one-hot accept, asserted only in a grant cycle
//   disp_char   - character driven to the display (IDLE_CHAR when blank)
//   disp_owner  - index of the requester currently shown
//   disp_busy   - high while a character is being shown
//   dwell_done  - pulse on the last cycle of a dwell
module char_display_scheduler
    import char_disp_pkg::*;
#(
    parameter int          NUM_REQ     = 4,
    parameter int          TICK_DIV    = 25_000_000,
    parameter int          DWELL_TICKS = 1,
    parameter logic [7:0]  IDLE_CHAR   = DEFAULT_IDLE_CHAR
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [8*NUM_REQ-1:0]         req_char,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [7:0]                   disp_char,
    output logic [widthOf(NUM_REQ)-1:0]  disp_owner,
    output logic                         disp_busy,
    output logic                         dwell_done
);

    localparam int IDX_W   = widthOf(NUM_REQ);
    localparam int PRE_W   = widthOf(TICK_DIV);
    localparam int DWELL_W = $clog2(DWELL_TICKS + 1);

    dispState_e           state_q;
    logic [PRE_W-1:0]     prescale_q;
    logic [DWELL_W-1:0]   dwell_q;
    logic [IDX_W-1:0]     lastOwner_q;
    logic [7:0]           dispChar_q;
    logic [IDX_W-1:0]     dispOwner_q;
    logic                 dispBusy_q;

    logic [NUM_REQ-1:0]   grantVec;
    logic [IDX_W-1:0]     grantIdx;
    logic                 anyReq;
    logic                 tickEnd;
    logic                 expiry;
    logic                 grantFire;
    logic [7:0]           winChar;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arbiter (
        .reqVec_i    (req_valid),
        .lastOwner_i (lastOwner_q),
        .grant_o     (grantVec),
        .grantIdx_o  (grantIdx),
        .any_o       (anyReq)
    );

    // Control strobes, all decoded from the current registers.
    // A grant can only happen from IDLE or on the expiry cycle of a dwell.
    // Requests that arrive mid-dwell therefore see ready low until the dwell
    // ends. Reset masks the grant so that nothing is accepted while rst is
    // high.
    always_comb begin
        tickEnd   = (prescale_q == PRE_W'(TICK_DIV - 1));
        expiry    = (state_q == ST_SHOW) && tickEnd &&
                    (dwell_q == DWELL_W'(DWELL_TICKS - 1));
        grantFire = !rst && anyReq && ((state_q == ST_IDLE) || expiry);
    end

    // Pick the character of the winning requester. The grant vector is
    // one-hot, so at most one slice is selected.
    always_comb begin
        winChar = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grantVec[i]) begin
                winChar = req_char[8*i +: 8];
            end
        end
    end

    // The whole scheduler FSM lives in this block: display registers,
    // prescaler and dwell counter.
    // A grant loads the new character and restarts both counters. This
    // applies even on the expiry cycle, which is how back-to-back characters
    // avoid a blank gap.
    // The prescaler wraps at TICK_DIV-1 and the dwell counter stops at
    // DWELL_TICKS-1, so neither counter runs past its terminal value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            prescale_q  <= '0;
            dwell_q     <= '0;
            lastOwner_q <= IDX_W'(NUM_REQ - 1);
            dispChar_q  <= IDLE_CHAR;
            dispOwner_q <= '0;
            dispBusy_q  <= 1'b0;
        end else if (grantFire) begin
            state_q     <= ST_SHOW;
            prescale_q  <= '0;
            dwell_q     <= '0;
            lastOwner_q <= grantIdx;
            dispChar_q  <= winChar;
            dispOwner_q <= grantIdx;
            dispBusy_q  <= 1'b1;
        end else if (state_q == ST_SHOW) begin
            if (expiry) begin
                state_q    <= ST_IDLE;
                prescale_q <= '0;
                dwell_q    <= '0;
                dispChar_q <= IDLE_CHAR;
                dispBusy_q <= 1'b0;
            end else if (tickEnd) begin
                prescale_q <= '0;
                dwell_q    <= dwell_q + 1'b1;
            end else begin
                prescale_q <= prescale_q + 1'b1;
            end
        end
    end

    // Drive the outputs. Ready and dwell_done are strobes within the
    // current cycle, so they are decoded rather than registered.
    // Both strobes are forced low while reset is held.
    always_comb begin
        req_ready  = grantFire ? grantVec : '0;
        dwell_done = !rst && expiry;
        disp_char  = dispChar_q;
        disp_owner = dispOwner_q;
        disp_busy  = dispBusy_q;
    end

endmodule

// File: tb/tb_char_display_scheduler.sv
// Directed testbench for char_display_scheduler with NUM_REQ=4, TICK_DIV=4
// and DWELL_TICKS=2, which gives an 8-cycle dwell.
// Inputs change 1 ns after the rising edge. Outputs are compared 1 ns after
// that, well away from the active edge. Every expected value below is worked
// out by hand from the scheduling rules.
module tb_char_display_scheduler;

    localparam int NUM_REQ     = 4;
    localparam int TICK_DIV    = 4;
    localparam int DWELL_TICKS = 2;
    localparam int DWELL_LEN   = TICK_DIV * DWELL_TICKS;

    logic                 clk;
    logic                 rst;
    logic [NUM_REQ-1:0]   reqValid;
    logic [8*NUM_REQ-1:0] reqChar;
    logic [NUM_REQ-1:0]   reqReady;
    logic [7:0]           dispChar;
    logic [1:0]           dispOwner;
    logic                 dispBusy;
    logic                 dwellDone;

    int errorCount;
    int checkCount;

    char_display_scheduler #(
        .NUM_REQ     (NUM_REQ),
        .TICK_DIV    (TICK_DIV),
        .DWELL_TICKS (DWELL_TICKS),
        .IDLE_CHAR   (8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (reqValid),
        .req_char   (reqChar),
        .req_ready  (reqReady),
        .disp_char  (dispChar),
        .disp_owner (dispOwner),
        .disp_busy  (dispBusy),
        .dwell_done (dwellDone)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends, even if the stimulus stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the request inputs, then let the combinational outputs settle.
    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid,
                                 input logic [8*NUM_REQ-1:0] chars);
        reqValid = valid;
        reqChar  = chars;
        #1;
    endtask

    // One comparison: counted, and reported with a FAIL line on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Check the registered display outputs.
    task automatic checkDisplay(input string tag, input logic [7:0] ch,
                                input logic [1:0] owner, input logic busy);
        checkOutput({tag, ".char"},  32'(dispChar),  32'(ch));
        checkOutput({tag, ".owner"}, 32'(dispOwner), 32'(owner));
        checkOutput({tag, ".busy"},  32'(dispBusy),  32'(busy));
    endtask

    // Start in the first SHOW cycle of a dwell and walk through all of its
    // cycles. The walk ends on the expiry cycle without advancing past it.
    // Ready must stay low until the expiry cycle. On that cycle it must equal
    // expReady.
    task automatic runDwell(input string tag, input logic [7:0] ch,
                            input logic [1:0] owner,
                            input logic [NUM_REQ-1:0] expReady);
        for (int i = 0; i < DWELL_LEN; i++) begin
            checkDisplay(tag, ch, owner, 1'b1);
            checkOutput({tag, ".done"}, 32'(dwellDone), 32'(i == DWELL_LEN - 1));
            checkOutput({tag, ".ready"}, 32'(reqReady),
                        (i == DWELL_LEN - 1) ? 32'(expReady) : 32'h0);
            if (i < DWELL_LEN - 1) tick();
        end
    endtask

    initial begin
        errorCount = 0;
        checkCount = 0;
        rst        = 1'b1;
        reqValid   = '0;
        reqChar    = '0;

        // Hold reset with every requester valid: nothing may be granted.
        applyStimulus(4'b1111, {8'h33, 8'h32, 8'h31, 8'h30});
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("rst.ready", 32'(reqReady), 32'h0);
            checkOutput("rst.done",  32'(dwellDone), 32'h0);
            checkDisplay("rst", 8'h00, 2'd0, 1'b0);
        end
        rst = 1'b0;
        applyStimulus(4'b0000, '0);
        tick();
        checkDisplay("idle", 8'h00, 2'd0, 1'b0);

        // A single request on requester 2.
        applyStimulus(4'b0100, {8'h00, 8'h41, 8'h00, 8'h00});
        checkOutput("single.grant", 32'(reqReady), 32'b0100);
        tick();
        applyStimulus(4'b0000, '0);
        runDwell("single", 8'h41, 2'd2, 4'b0000);
        tick();
        checkDisplay("single.blank", 8'h00, 2'd2, 1'b0);

        // Reset so the pointer favours requester 0, then all four are valid.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(4'b1111, {8'h33, 8'h32, 8'h31, 8'h30});
        checkOutput("all.grant0", 32'(reqReady), 32'b0001);
        tick();
        applyStimulus(4'b1110, {8'h33, 8'h32, 8'h31, 8'h30});
        runDwell("all0", 8'h30, 2'd0, 4'b0010);
        tick();
        applyStimulus(4'b1100, {8'h33, 8'h32, 8'h31, 8'h30});
        runDwell("all1", 8'h31, 2'd1, 4'b0100);
        tick();
        applyStimulus(4'b1000, {8'h33, 8'h32, 8'h31, 8'h30});
        runDwell("all2", 8'h32, 2'd2, 4'b1000);
        tick();
        applyStimulus(4'b0000, '0);
        runDwell("all3", 8'h33, 2'd3, 4'b0000);
        tick();
        checkDisplay("all.blank", 8'h00, 2'd3, 1'b0);

        // Serve requester 1, then have 0 and 2 contend: 2 must win first.
        applyStimulus(4'b0010, {8'h00, 8'h00, 8'h51, 8'h00});
        checkOutput("rr.grant1", 32'(reqReady), 32'b0010);
        tick();
        applyStimulus(4'b0101, {8'h00, 8'h62, 8'h00, 8'h60});
        runDwell("rr1", 8'h51, 2'd1, 4'b0100);
        tick();
        applyStimulus(4'b0001, {8'h00, 8'h62, 8'h00, 8'h60});
        runDwell("rr2", 8'h62, 2'd2, 4'b0001);
        tick();
        applyStimulus(4'b0000, '0);
        runDwell("rr0", 8'h60, 2'd0, 4'b0000);
        tick();
        checkDisplay("rr.blank", 8'h00, 2'd0, 1'b0);

        // Requester 3 raises valid during the third cycle of requester 0's dwell.
        applyStimulus(4'b0001, {8'h00, 8'h00, 8'h00, 8'h30});
        checkOutput("late.grant0", 32'(reqReady), 32'b0001);
        tick();
        applyStimulus(4'b0000, '0);
        for (int i = 0; i < DWELL_LEN; i++) begin
            if (i == 2) applyStimulus(4'b1000, {8'h33, 8'h00, 8'h00, 8'h00});
            checkOutput("late.char",  32'(dispChar), 32'h30);
            checkOutput("late.ready", 32'(reqReady),
                        (i == DWELL_LEN - 1) ? 32'b1000 : 32'h0);
            if (i < DWELL_LEN - 1) tick();
        end
        tick();
        applyStimulus(4'b0000, '0);
        runDwell("late3", 8'h33, 2'd3, 4'b0000);
        tick();
        checkDisplay("late.blank", 8'h00, 2'd3, 1'b0);

        // Reset during the third cycle of requester 1's dwell, with 3 and 0
        // pending. Reset restores the pointer, so requester 0 wins.
        applyStimulus(4'b0010, {8'h00, 8'h00, 8'h31, 8'h00});
        tick();
        applyStimulus(4'b0000, '0);
        tick();
        tick();
        checkDisplay("mid.show", 8'h31, 2'd1, 1'b1);
        rst = 1'b1;
        applyStimulus(4'b1001, {8'h33, 8'h00, 8'h00, 8'h30});
        checkOutput("mid.rstReady", 32'(reqReady), 32'h0);
        tick();
        checkDisplay("mid.rstEdge", 8'h00, 2'd0, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("mid.grant0", 32'(reqReady), 32'b0001);
        tick();
        applyStimulus(4'b1000, {8'h33, 8'h00, 8'h00, 8'h30});
        runDwell("mid0", 8'h30, 2'd0, 4'b1000);
        tick();
        applyStimulus(4'b0000, '0);
        runDwell("mid3", 8'h33, 2'd3, 4'b0000);
        tick();
        checkDisplay("mid.blank", 8'h00, 2'd3, 1'b0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
